// File: rtl/m_div_sequencer_pkg.sv
// Shared state encoding, op-select constants and sign helper for the
// iterative RV32 divider.
package m_div_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

  localparam logic DIV_OP_QUO = 1'b0;
  localparam logic DIV_OP_REM = 1'b1;

  // {q_neg, r_neg}: quotient sign follows both operands, remainder follows the dividend
  function automatic logic [1:0] div_sign_flags(input logic sgn, input logic a_msb,
                                                input logic b_msb);
    return {sgn & (a_msb ^ b_msb), sgn & a_msb};
  endfunction

endpackage

// File: rtl/m_div_step.sv
// One combinational radix-2 restoring iteration; the compare/subtract runs
// on WIDTH+1 bits so the borrow out of the shifted remainder is never lost.
module m_div_step
  import m_div_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0] w_shift_rem;
  logic [WIDTH:0] w_diff;
  logic           w_ge;

  assign w_shift_rem = {i_rem, i_quo[WIDTH-1]};
  assign w_diff      = w_shift_rem - {1'b0, i_divisor};
  // shifted remainder < 2*divisor, so the top bit of the difference is the borrow
  assign w_ge        = ~w_diff[WIDTH];

  assign o_rem = w_ge ? w_diff[WIDTH-1:0] : w_shift_rem[WIDTH-1:0];
  assign o_quo = {i_quo[WIDTH-2:0], w_ge};

endmodule

// File: rtl/m_div_sequencer.sv
// Multi-cycle restoring divider with IDLE/BUSY/DONE sequencing for div/rem,
// stalling the processor until the registered result is presented.
module m_div_sequencer
  import m_div_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_op_rem,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_stall,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       r_state;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_divisor;
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_op_rem;
  logic             r_done;
  logic [WIDTH-1:0] r_result;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_abs;
  logic [WIDTH-1:0] w_b_abs;
  logic             w_div_zero;
  logic             w_ovf;
  logic [WIDTH-1:0] w_next_rem;
  logic [WIDTH-1:0] w_next_quo;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;

  assign w_a_neg    = i_signed & i_dividend[WIDTH-1];
  assign w_b_neg    = i_signed & i_divisor[WIDTH-1];
  assign w_a_abs    = w_a_neg ? -i_dividend : i_dividend;
  assign w_b_abs    = w_b_neg ? -i_divisor : i_divisor;
  assign w_div_zero = (i_divisor == {WIDTH{1'b0}});
  assign w_ovf      = i_signed & (i_dividend == MOST_NEG) & (i_divisor == {WIDTH{1'b1}});

  m_div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_divisor),
    .o_rem     (w_next_rem),
    .o_quo     (w_next_quo)
  );

  // sign correction is folded into the last BUSY edge so o_result is a clean register in DONE
  assign w_quo_fix = r_q_neg ? -w_next_quo : w_next_quo;
  assign w_rem_fix = r_r_neg ? -w_next_rem : w_next_rem;

  // Sequencing FSM: capture, iterate, present the result for one cycle
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_count   <= {CNT_W{1'b0}};
      r_rem     <= {WIDTH{1'b0}};
      r_quo     <= {WIDTH{1'b0}};
      r_divisor <= {WIDTH{1'b0}};
      r_q_neg   <= 1'b0;
      r_r_neg   <= 1'b0;
      r_op_rem  <= DIV_OP_QUO;
      r_done    <= 1'b0;
      r_result  <= {WIDTH{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_op_rem             <= i_op_rem;
            r_rem                <= {WIDTH{1'b0}};
            r_quo                <= w_a_abs;
            r_divisor            <= w_b_abs;
            r_count              <= CNT_INIT;
            {r_q_neg, r_r_neg}   <= div_sign_flags(i_signed, i_dividend[WIDTH-1],
                                                   i_divisor[WIDTH-1]);
            if (w_div_zero) begin
              r_result <= (i_op_rem == DIV_OP_REM) ? i_dividend : {WIDTH{1'b1}};
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else if (w_ovf) begin
              r_result <= (i_op_rem == DIV_OP_REM) ? {WIDTH{1'b0}} : i_dividend;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_state <= S_BUSY;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_BUSY: begin
          r_rem <= w_next_rem;
          r_quo <= w_next_quo;
          if (r_count == {CNT_W{1'b0}}) begin
            r_result <= (r_op_rem == DIV_OP_REM) ? w_rem_fix : w_quo_fix;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_count <= r_count - CNT_ONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_stall  = ((r_state == S_IDLE) & i_start) | (r_state == S_BUSY);
  assign o_busy   = (r_state == S_BUSY);
  assign o_done   = r_done;
  assign o_result = r_result;

endmodule

// File: tb/tb_m_div_sequencer.sv
// Scoreboard bench for m_div_sequencer: stimulus pushes expected result and
// completion cycle, a negedge monitor pops and compares on every o_done.
module tb_m_div_sequencer;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         start;
  logic         op_rem;
  logic         sgn;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         stall;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  typedef struct {
    logic [W-1:0] res;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int   cyc;
  int   n_checks;
  int   n_pass;

  m_div_sequencer #(.WIDTH(W)) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_start    (start),
    .i_op_rem   (op_rem),
    .i_signed   (sgn),
    .i_dividend (dividend),
    .i_divisor  (divisor),
    .o_stall    (stall),
    .o_busy     (busy),
    .o_done     (done),
    .o_result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: RISC-V div/rem semantics with plain integer arithmetic
  function automatic logic [W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input bit s, input bit r);
    longint sa, sb;
    if (b == 32'd0) return r ? a : 32'hFFFF_FFFF;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return r ? W'(sa % sb) : W'(sa / sb);
    end
    return r ? (a % b) : (a / b);
  endfunction

  function automatic bit is_special(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
    return (b == 32'd0) || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Issue one instruction at the next negedge; check stall/busy each cycle until DONE
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                       input bit r, input bit keep, input logic [W-1:0] exp_res);
    int   lat;
    int   c0;
    exp_t e;
    lat = is_special(a, b, s) ? 1 : W + 1;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b; sgn = s; op_rem = r;
    c0 = cyc;
    e.res = exp_res;
    e.cyc = c0 + lat;
    q.push_back(e);
    #1;
    chk("stall_capture", {31'd0, stall}, 32'd1);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == lat && !keep) start = 1'b0;
      #1;
      if (k == 1 || k == lat || k == 10) begin
        chk("stall", {31'd0, stall}, (k < lat) ? 32'd1 : 32'd0);
        chk("busy", {31'd0, busy}, (k < lat) ? 32'd1 : 32'd0);
      end
    end
  endtask

  // Monitor: every o_done must match the oldest pending expectation
  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: o_done at cycle %0d with nothing pending, result %h",
                 cyc, result);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result", result, e.res);
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] a, b;
    bit           s, r;
    int           c0;
    n_checks = 0; n_pass = 0;
    reset = 1'b1; start = 1'b0; op_rem = 1'b0; sgn = 1'b0;
    dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    reset = 1'b0;

    do_op(32'd100, 32'd7, 1'b0, 1'b0, 1'b0, 32'd14);
    do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF);
    do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFD);
    do_op(32'h0000_1234, 32'd0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
    do_op(32'h0000_1234, 32'd0, 1'b0, 1'b1, 1'b0, 32'h0000_1234);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 32'h8000_0000);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 32'd0);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'd0);

    // Abort in BUSY cycle 10: no o_done may follow, outputs clear
    @(negedge clk);
    start = 1'b1; dividend = 32'd1000; divisor = 32'd3; sgn = 1'b0; op_rem = 1'b0;
    c0 = cyc;
    repeat (10) @(negedge clk);
    reset = 1'b1; start = 1'b0;
    @(negedge clk);
    #1;
    chk("abort_stall", {31'd0, stall}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_result", result, 32'd0);
    reset = 1'b0;
    do_op(32'd1000, 32'd3, 1'b0, 1'b0, 1'b0, 32'd333);

    // Back-to-back with i_start held: second capture on the IDLE cycle after DONE
    do_op(32'd100, 32'd7, 1'b0, 1'b0, 1'b1, 32'd14);
    do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFD);

    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = W'($urandom_range(1, 15));
        3: b = a;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      s = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      do_op(a, b, s, r, 1'b0, ref_div(a, b, s, r));
    end

    repeat (40) @(negedge clk);
    chk("pending_drained", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
